// File: rtl/branch_update_scheduler_if.sv
// Port bundle between fetch/execute and the branch update scheduler.
// The producer side (fetch, execute) uses the master modport; the scheduler uses slave.
interface branch_update_scheduler_if #(
    parameter int QUEUE_DEPTH = 4,
    parameter int INDEX_WIDTH = 6
);
    logic                                   lookup_req;
    logic [INDEX_WIDTH-1:0]                 lookup_index;
    logic                                   lookup_grant;
    logic                                   upd_valid;
    logic [INDEX_WIDTH-1:0]                 upd_index;
    logic                                   upd_taken;
    logic                                   upd_ready;
    logic                                   tbl_en;
    logic                                   tbl_we;
    logic [INDEX_WIDTH-1:0]                 tbl_index;
    logic                                   tbl_wdata_taken;
    logic [$clog2(QUEUE_DEPTH+1)-1:0]       queue_count;

    modport master (
        output lookup_req, lookup_index, upd_valid, upd_index, upd_taken,
        input  lookup_grant, upd_ready, tbl_en, tbl_we, tbl_index, tbl_wdata_taken, queue_count
    );

    modport slave (
        input  lookup_req, lookup_index, upd_valid, upd_index, upd_taken,
        output lookup_grant, upd_ready, tbl_en, tbl_we, tbl_index, tbl_wdata_taken, queue_count
    );
endinterface

// File: rtl/branch_update_scheduler.sv
// Shares one predictor-table port between fetch lookups and a FIFO of resolved
// branch updates. Lookups win by default; a starvation counter forces the head
// update out after STARVE_LIMIT consecutive lookup grants with updates pending.
module branch_update_scheduler #(
    parameter int QUEUE_DEPTH  = 4,
    parameter int INDEX_WIDTH  = 6,
    parameter int STARVE_LIMIT = 3
) (
    input logic                     clk,
    input logic                     reset,
    branch_update_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH+1);
    localparam int SC_W  = $clog2(STARVE_LIMIT+1);

    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [SC_W-1:0]        starve_q, starve_d;

    // Queue payload is not reset: entries are only read once counted as valid.
    logic [INDEX_WIDTH-1:0] idx_mem_q [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] taken_mem_q;

    logic empty_w;
    logic upd_ready_w;
    logic issue_upd_w;
    logic issue_lkp_w;
    logic enq_w;
    logic deq_w;

    // Arbitration: forced update when starved, else lookup, else drain the queue.
    always_comb begin
        empty_w     = (count_q == '0);
        upd_ready_w = !reset && (count_q < CNT_W'(QUEUE_DEPTH));
        issue_upd_w = 1'b0;
        issue_lkp_w = 1'b0;
        if (!reset) begin
            if (!empty_w && (starve_q == SC_W'(STARVE_LIMIT))) begin
                issue_upd_w = 1'b1;
            end else if (bus.lookup_req) begin
                issue_lkp_w = 1'b1;
            end else if (!empty_w) begin
                issue_upd_w = 1'b1;
            end
        end
        enq_w = bus.upd_valid && upd_ready_w;
        deq_w = issue_upd_w;
    end

    // Table port drive; everything is held at zero during reset or when idle.
    always_comb begin
        bus.lookup_grant    = 1'b0;
        bus.tbl_en          = 1'b0;
        bus.tbl_we          = 1'b0;
        bus.tbl_index       = '0;
        bus.tbl_wdata_taken = 1'b0;
        if (issue_upd_w) begin
            bus.tbl_en          = 1'b1;
            bus.tbl_we          = 1'b1;
            bus.tbl_index       = idx_mem_q[rd_ptr_q];
            bus.tbl_wdata_taken = taken_mem_q[rd_ptr_q];
        end else if (issue_lkp_w) begin
            bus.lookup_grant = 1'b1;
            bus.tbl_en       = 1'b1;
            bus.tbl_index    = bus.lookup_index;
        end
        bus.upd_ready   = upd_ready_w;
        bus.queue_count = count_q;
    end

    // Next-state for pointers, occupancy and the starvation counter.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        if (enq_w) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (deq_w) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({enq_w, deq_w})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (issue_upd_w || empty_w) begin
            starve_d = '0;
        end else if (issue_lkp_w && (starve_q != SC_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + SC_W'(1);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // Queue storage write on accepted update.
    always_ff @(posedge clk) begin
        if (enq_w) begin
            idx_mem_q[wr_ptr_q]   <= bus.upd_index;
            taken_mem_q[wr_ptr_q] <= bus.upd_taken;
        end
    end
endmodule

// File: tb/tb_branch_update_scheduler.sv
// Self-checking bench for branch_update_scheduler (QUEUE_DEPTH=4, INDEX_WIDTH=6, STARVE_LIMIT=3).
module tb_branch_update_scheduler;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   wr_count = 0;

    typedef struct packed {
        logic [5:0] idx;
        logic       taken;
    } upd_t;
    upd_t sb[$];

    branch_update_scheduler_if #(.QUEUE_DEPTH(4), .INDEX_WIDTH(6)) bus ();

    branch_update_scheduler #(.QUEUE_DEPTH(4), .INDEX_WIDTH(6), .STARVE_LIMIT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: compare each table write against the oldest accepted update,
    // then record any update accepted at the coming edge.
    always @(negedge clk) begin
        upd_t e;
        if (bus.tbl_we) begin
            n_cmp++;
            wr_count++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got idx %0d taken %0d, required no write", bus.tbl_index, bus.tbl_wdata_taken);
            end else begin
                e = sb.pop_front();
                if ({bus.tbl_index, bus.tbl_wdata_taken} !== {e.idx, e.taken}) begin
                    n_fail++;
                    $display("FAIL sb_write_order: got idx %0d taken %0d, required idx %0d taken %0d",
                             bus.tbl_index, bus.tbl_wdata_taken, e.idx, e.taken);
                end
            end
        end
        if (!reset && bus.upd_valid && bus.upd_ready) begin
            e.idx   = bus.upd_index;
            e.taken = bus.upd_taken;
            sb.push_back(e);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.lookup_req = 1'b1; bus.lookup_index = 6'd12;
        bus.upd_valid = 1'b1;  bus.upd_index = 6'd3; bus.upd_taken = 1'b1;
        step; step; #1;
        n_cmp++; if (bus.lookup_grant !== 1'b0) begin n_fail++; $display("FAIL rst_grant: got %0b, required 0", bus.lookup_grant); end
        n_cmp++; if (bus.tbl_en !== 1'b0) begin n_fail++; $display("FAIL rst_tbl_en: got %0b, required 0", bus.tbl_en); end
        n_cmp++; if (bus.tbl_we !== 1'b0) begin n_fail++; $display("FAIL rst_tbl_we: got %0b, required 0", bus.tbl_we); end
        n_cmp++; if (bus.tbl_index !== 6'd0) begin n_fail++; $display("FAIL rst_tbl_index: got %0d, required 0", bus.tbl_index); end
        n_cmp++; if (bus.tbl_wdata_taken !== 1'b0) begin n_fail++; $display("FAIL rst_wdata: got %0b, required 0", bus.tbl_wdata_taken); end
        n_cmp++; if (bus.upd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_upd_ready: got %0b, required 0", bus.upd_ready); end
        n_cmp++; if (bus.queue_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", bus.queue_count); end
        reset = 1'b0;
        bus.lookup_req = 1'b0; bus.lookup_index = 6'd0;
        bus.upd_valid = 1'b0;  bus.upd_index = 6'd0; bus.upd_taken = 1'b0;
        #1;
        n_cmp++; if (bus.upd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %0b, required 1", bus.upd_ready); end
        n_cmp++; if (bus.tbl_en !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got tbl_en %0b, required 0", bus.tbl_en); end
        step;
    endtask

    task automatic test_idle_lookup;
        bus.lookup_req = 1'b1; bus.lookup_index = 6'd5;
        #1;
        n_cmp++; if (bus.lookup_grant !== 1'b1) begin n_fail++; $display("FAIL idle_grant: got %0b, required 1", bus.lookup_grant); end
        n_cmp++; if ({bus.tbl_en, bus.tbl_we} !== 2'b10) begin n_fail++; $display("FAIL idle_en_we: got %b, required 10", {bus.tbl_en, bus.tbl_we}); end
        n_cmp++; if (bus.tbl_index !== 6'd5) begin n_fail++; $display("FAIL idle_index: got %0d, required 5", bus.tbl_index); end
        step;
        bus.lookup_req = 1'b0; bus.lookup_index = 6'd0;
    endtask

    task automatic test_update_latency;
        bus.upd_valid = 1'b1; bus.upd_index = 6'd9; bus.upd_taken = 1'b1;
        #1;
        n_cmp++; if (bus.tbl_en !== 1'b0) begin n_fail++; $display("FAIL lat_no_bypass: got tbl_en %0b, required 0", bus.tbl_en); end
        n_cmp++; if (bus.upd_ready !== 1'b1) begin n_fail++; $display("FAIL lat_ready: got %0b, required 1", bus.upd_ready); end
        step;
        bus.upd_valid = 1'b0; bus.upd_index = 6'd0; bus.upd_taken = 1'b0;
        #1;
        n_cmp++; if (bus.tbl_we !== 1'b1) begin n_fail++; $display("FAIL lat_n1_we: got %0b, required 1", bus.tbl_we); end
        n_cmp++; if (bus.tbl_index !== 6'd9) begin n_fail++; $display("FAIL lat_n1_index: got %0d, required 9", bus.tbl_index); end
        n_cmp++; if (bus.tbl_wdata_taken !== 1'b1) begin n_fail++; $display("FAIL lat_n1_taken: got %0b, required 1", bus.tbl_wdata_taken); end
        n_cmp++; if (bus.queue_count !== 3'd1) begin n_fail++; $display("FAIL lat_n1_count: got %0d, required 1", bus.queue_count); end
        step;
        n_cmp++; if (bus.queue_count !== 3'd0) begin n_fail++; $display("FAIL lat_n2_count: got %0d, required 0", bus.queue_count); end
        n_cmp++; if (bus.tbl_en !== 1'b0) begin n_fail++; $display("FAIL lat_n2_idle: got tbl_en %0b, required 0", bus.tbl_en); end
    endtask

    task automatic test_starvation;
        bus.lookup_req = 1'b1; bus.lookup_index = 6'd7;
        bus.upd_valid = 1'b1; bus.upd_index = 6'd20; bus.upd_taken = 1'b0;
        step;
        bus.upd_valid = 1'b0; bus.upd_index = 6'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({bus.lookup_grant, bus.tbl_we} !== 2'b10) begin
                n_fail++; $display("FAIL starve_lookup_%0d: got grant/we %b, required 10", i, {bus.lookup_grant, bus.tbl_we});
            end
            step;
        end
        #1;
        n_cmp++; if ({bus.lookup_grant, bus.tbl_we} !== 2'b01) begin n_fail++; $display("FAIL starve_forced: got grant/we %b, required 01", {bus.lookup_grant, bus.tbl_we}); end
        n_cmp++; if (bus.tbl_index !== 6'd20) begin n_fail++; $display("FAIL starve_index: got %0d, required 20", bus.tbl_index); end
        step;
        #1;
        n_cmp++; if (bus.lookup_grant !== 1'b1) begin n_fail++; $display("FAIL starve_resume: got %0b, required 1", bus.lookup_grant); end
        n_cmp++; if (bus.queue_count !== 3'd0) begin n_fail++; $display("FAIL starve_count: got %0d, required 0", bus.queue_count); end
        bus.lookup_req = 1'b0;
        step;
    endtask

    task automatic test_full;
        int guard;
        bus.lookup_req = 1'b1; bus.lookup_index = 6'd1;
        for (int i = 0; i < 4; i++) begin
            bus.upd_valid = 1'b1; bus.upd_index = 6'(30 + i); bus.upd_taken = i[0];
            #1;
            n_cmp++; if (bus.lookup_grant !== 1'b1) begin n_fail++; $display("FAIL full_fill_grant_%0d: got %0b, required 1", i, bus.lookup_grant); end
            step;
        end
        bus.upd_index = 6'd34; bus.upd_taken = 1'b1;
        #1;
        n_cmp++; if (bus.queue_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d, required 4", bus.queue_count); end
        n_cmp++; if (bus.upd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b, required 0", bus.upd_ready); end
        n_cmp++; if ({bus.tbl_we, bus.tbl_index} !== {1'b1, 6'd30}) begin n_fail++; $display("FAIL full_forced_write: got we %0b idx %0d, required we 1 idx 30", bus.tbl_we, bus.tbl_index); end
        step;
        #1;
        n_cmp++; if (bus.upd_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_drain: got %0b, required 1", bus.upd_ready); end
        step;
        bus.upd_valid = 1'b0; bus.lookup_req = 1'b0;
        guard = 0;
        while (bus.queue_count != 3'd0 && guard < 20) begin step; guard++; end
        n_cmp++; if (bus.queue_count !== 3'd0) begin n_fail++; $display("FAIL full_drain_timeout: got count %0d, required 0", bus.queue_count); end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL full_sb_left: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_order_wrap;
        int  guard;
        int  wr0;
        logic acc;
        wr0 = wr_count;
        for (int i = 0; i < 10; i++) begin
            bus.upd_valid = 1'b1; bus.upd_index = 6'(i); bus.upd_taken = i[0];
            guard = 0;
            do begin
                bus.lookup_req = 1'($urandom_range(0, 1));
                bus.lookup_index = 6'($urandom_range(0, 63));
                #1;
                acc = bus.upd_ready;
                step;
                guard++;
            end while (!acc && guard < 50);
        end
        bus.upd_valid = 1'b0; bus.lookup_req = 1'b0;
        guard = 0;
        while (bus.queue_count != 3'd0 && guard < 20) begin step; guard++; end
        n_cmp++; if (bus.queue_count !== 3'd0) begin n_fail++; $display("FAIL order_final_count: got %0d, required 0", bus.queue_count); end
        n_cmp++; if (wr_count - wr0 != 10) begin n_fail++; $display("FAIL order_write_count: got %0d, required 10", wr_count - wr0); end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL order_sb_left: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_reset_mid;
        int wr0;
        bus.lookup_req = 1'b1; bus.lookup_index = 6'd2;
        for (int i = 0; i < 3; i++) begin
            bus.upd_valid = 1'b1; bus.upd_index = 6'(40 + i); bus.upd_taken = 1'b1;
            step;
        end
        bus.upd_valid = 1'b0;
        #1;
        n_cmp++; if (bus.queue_count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count: got %0d, required 3", bus.queue_count); end
        reset = 1'b1;
        #1;
        n_cmp++; if ({bus.tbl_en, bus.upd_ready} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_outputs: got en/ready %b, required 00", {bus.tbl_en, bus.upd_ready}); end
        step;
        reset = 1'b0;
        sb.delete();
        wr0 = wr_count;
        bus.lookup_index = 6'd17;
        #1;
        n_cmp++; if (bus.queue_count !== 3'd0) begin n_fail++; $display("FAIL mid_post_count: got %0d, required 0", bus.queue_count); end
        n_cmp++; if ({bus.lookup_grant, bus.tbl_we} !== 2'b10) begin n_fail++; $display("FAIL mid_post_grant: got grant/we %b, required 10", {bus.lookup_grant, bus.tbl_we}); end
        n_cmp++; if (bus.tbl_index !== 6'd17) begin n_fail++; $display("FAIL mid_post_index: got %0d, required 17", bus.tbl_index); end
        step;
        bus.lookup_req = 1'b0;
        repeat (4) step;
        n_cmp++; if (wr_count != wr0) begin n_fail++; $display("FAIL mid_discarded_written: got %0d writes, required 0", wr_count - wr0); end
    endtask

    initial begin
        reset = 1'b1;
        bus.lookup_req = 1'b0; bus.lookup_index = 6'd0;
        bus.upd_valid = 1'b0;  bus.upd_index = 6'd0; bus.upd_taken = 1'b0;
        #1;
        test_reset;
        test_idle_lookup;
        test_update_latency;
        test_starvation;
        test_full;
        test_order_wrap;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
